// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: latches device IRQs as pending, masks them, and hands one request at a time to the CPU.
// Optional round-robin priority: define IRQ_CTRL_ROTATE_PRIO_EN; otherwise the lowest index wins.
module irq_ctrl #(
    parameter int N_IRQ = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [1:0]       addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic [N_IRQ-1:0] irq_in,
    output logic             int_req,
    input  logic             int_ack,
    output logic [2:0]       int_id
);
    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t           state;
    logic [1:0]       ctrl;
    logic [N_IRQ-1:0] mask, pend, irq_prev;
    logic [N_IRQ-1:0] w1c, ack_clr;
    logic [7:0]       cand8, id_onehot;
    logic [2:0]       start, pick_id;
    logic [3:0]       idx;
    logic             pick_vld;
    logic             en, edge_mode;
    logic             wr_ctrl, wr_mask, wr_pend, wr_stat, ack_fire;

    assign en        = ctrl[0];
    assign edge_mode = ctrl[1];
    assign wr_ctrl   = WE && (addr == 2'd0);
    assign wr_mask   = WE && (addr == 2'd1);
    assign wr_pend   = WE && (addr == 2'd2);
    assign wr_stat   = WE && (addr == 2'd3);
    assign ack_fire  = (state == REQ) && int_ack;

    // 8-bit views let a 3-bit int_id index safely for any legal N_IRQ
    assign cand8     = 8'(pend & mask);
    assign id_onehot = 8'b1 << int_id;
    assign w1c       = (wr_pend && edge_mode) ? Din[N_IRQ-1:0] : '0;
    assign ack_clr   = (ack_fire && edge_mode) ? id_onehot[N_IRQ-1:0] : '0;

`ifdef IRQ_CTRL_ROTATE_PRIO_EN
    logic [2:0] last_id;

    always_ff @(posedge clk) begin
        if (clr)
            last_id <= 3'(N_IRQ - 1);
        else if (state == SERV && wr_stat)
            last_id <= int_id;
    end

    assign start = (last_id == 3'(N_IRQ - 1)) ? 3'd0 : last_id + 3'd1;
`else
    assign start = 3'd0;
`endif

    // Walk offsets from far to near so the nearest candidate after start wins
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            idx = {1'b0, start} + 4'(k);
            if (idx >= 4'(N_IRQ))
                idx = idx - 4'(N_IRQ);
            if (cand8[idx[2:0]]) begin
                pick_vld = 1'b1;
                pick_id  = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            ctrl     <= '0;
            mask     <= '0;
            pend     <= '0;
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_in;
            if (wr_ctrl) ctrl <= Din[1:0];
            if (wr_mask) mask <= Din[N_IRQ-1:0];
            // new edges are OR'd in last so they beat a same-cycle clear
            if (edge_mode)
                pend <= (pend & ~w1c & ~ack_clr) | (irq_in & ~irq_prev);
            else
                pend <= irq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            int_req <= 1'b0;
            int_id  <= '0;
        end else begin
            case (state)
                IDLE: if (en && pick_vld) begin
                    int_id  <= pick_id;
                    int_req <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (int_ack) begin
                    int_req <= 1'b0;
                    state   <= SERV;
                end else if (!en || !cand8[int_id]) begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
                SERV: if (wr_stat) state <= IDLE;
                default: begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Dout = '0;
        case (addr)
            2'd0: Dout[1:0]       = ctrl;
            2'd1: Dout[N_IRQ-1:0] = mask;
            2'd2: Dout[N_IRQ-1:0] = pend;
            2'd3: if (state == SERV) Dout = {1'b1, 28'b0, int_id};
            default: Dout = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{Din, id_onehot};
endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised + directed bench for irq_ctrl against a cycle-level behavioural model built from the register/handshake rules.
module tb_irq_ctrl;
    localparam int N = 6;

    logic          clk = 1'b0;
    logic          clr = 1'b1, WE = 1'b0, int_ack = 1'b0;
    logic [1:0]    addr = '0;
    logic [31:0]   Din = '0;
    logic [31:0]   Dout;
    logic [N-1:0]  irq_in = '0;
    logic          int_req;
    logic [2:0]    int_id;

    always #5 clk = ~clk;

    irq_ctrl #(.N_IRQ(N)) dut (
        .clk(clk), .clr(clr), .addr(addr), .WE(WE), .Din(Din), .Dout(Dout),
        .irq_in(irq_in), .int_req(int_req), .int_ack(int_ack), .int_id(int_id)
    );

    int errs = 0, checks = 0;
    int cur_irq = 0;

    // model state: st 0=idle 1=requesting 2=in service
    int m_ctrl = 0, m_mask = 0, m_pend = 0, m_prev = 0;
    int m_st = 0, m_req = 0, m_id = 0, m_last = N - 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_dout(input int a);
        case (a)
            0: return 32'(m_ctrl);
            1: return 32'(m_mask);
            2: return 32'(m_pend);
            default: return (m_st == 2) ? (32'h8000_0000 | 32'(m_id)) : 32'h0;
        endcase
    endfunction

    function automatic int m_pick(input int cand);
        int s;
`ifdef IRQ_CTRL_ROTATE_PRIO_EN
        s = (m_last + 1) % N;
`else
        s = 0;
`endif
        for (int j = 0; j < N; j++)
            if ((cand >> ((s + j) % N)) & 1) return (s + j) % N;
        return -1;
    endfunction

    task automatic model_next();
        int irq, a, d, en, edg, rise, keep, cand, nst, nreq, nid, nlast;
        if (clr) begin
            m_ctrl = 0; m_mask = 0; m_pend = 0; m_prev = 0;
            m_st = 0; m_req = 0; m_id = 0; m_last = N - 1;
            return;
        end
        irq = int'(irq_in); a = int'(addr); d = int'(Din);
        en = m_ctrl & 1; edg = (m_ctrl >> 1) & 1;
        cand = m_pend & m_mask;
        nst = m_st; nreq = m_req; nid = m_id; nlast = m_last;
        if (m_st == 0) begin
            if (en && cand != 0) begin nid = m_pick(cand); nst = 1; nreq = 1; end
        end else if (m_st == 1) begin
            if (int_ack) begin nst = 2; nreq = 0; end
            else if (!en || ((cand >> m_id) & 1) == 0) begin nst = 0; nreq = 0; end
        end else if (WE && a == 3) begin
            nst = 0; nlast = m_id;
        end
        if (edg) begin
            rise = irq & ~m_prev;
            keep = m_pend;
            if (WE && a == 2) keep = keep & ~d;
            if (m_st == 1 && int_ack) keep = keep & ~(1 << m_id);
            m_pend = (keep | rise) & ((1 << N) - 1);
        end else
            m_pend = irq;
        if (WE && a == 0) m_ctrl = d & 3;
        if (WE && a == 1) m_mask = d & ((1 << N) - 1);
        m_prev = irq;
        m_st = nst; m_req = nreq; m_id = nid; m_last = nlast;
    endtask

    task automatic cyc(input bit c, input bit we, input int a, input int d, input bit ack);
        @(negedge clk);
        clr = c; WE = we; addr = a[1:0]; Din = d; int_ack = ack; irq_in = cur_irq[N-1:0];
        #1;
        chk("int_req", {31'b0, int_req}, 32'(m_req));
        chk("int_id", {29'b0, int_id}, 32'(m_id));
        chk("dout", Dout, m_dout(a));
        model_next();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, int'($urandom % 4), 0, 0);
    endtask
    task automatic wr(input int a, input int d); cyc(0, 1, a, d, 0); endtask
    task automatic ack1(); cyc(0, 0, 3, 0, 1); endtask
    task automatic rst(); cyc(1, 0, 0, 0, 0); endtask

    initial begin
        rst(); rst();
        // level request, service, EOI with line still high
        wr(1, 'h3F); wr(0, 1); cur_irq = 'h04;
        idle(3); ack1(); idle(2); wr(3, 0); idle(3); ack1(); wr(3, 0);
        // edge mode, two lines pulse together
        cur_irq = 0; rst(); wr(1, 'h3F); wr(0, 3);
        cur_irq = 'h11; idle(1); cur_irq = 0; idle(2); ack1(); idle(1); wr(3, 0);
        idle(2); cyc(0, 0, 2, 0, 0); ack1(); cyc(0, 0, 2, 0, 0); wr(3, 0);
        // masking then unmask
        rst(); wr(1, 'h01); wr(0, 1); cur_irq = 'h08; idle(3); cyc(0, 0, 2, 0, 0);
        wr(1, 'h08); idle(3); ack1(); wr(3, 0);
        // withdraw in level mode, late ack ignored
        cur_irq = 0; rst(); wr(1, 'h3F); wr(0, 1); cur_irq = 'h02; idle(3);
        cur_irq = 0; idle(2); ack1(); idle(2);
        // same-cycle W1C vs rising edge, then reset while in service
        rst(); wr(1, 'h3F); wr(0, 3); cur_irq = 'h04; wr(2, 'h04); cyc(0, 0, 2, 0, 0);
        idle(1); ack1(); idle(1); cur_irq = 0; rst(); cyc(0, 0, 2, 0, 0); cyc(0, 0, 3, 0, 0);
        // two level lines held: fixed or round-robin service order
        wr(1, 'h3F); wr(0, 1); cur_irq = 'h03;
        for (int i = 0; i < 4; i++) begin idle(3); ack1(); idle(1); wr(3, 0); end
        // random traffic
        cur_irq = 0; rst();
        for (int i = 0; i < 4000; i++) begin
            int a, d;
            for (int b = 0; b < N; b++)
                if ($urandom % 8 == 0) cur_irq = cur_irq ^ (1 << b);
            a = int'($urandom % 4);
            d = int'($urandom);
            if (a == 0) d = (d & 2) | (($urandom % 8 != 0) ? 1 : 0);
            cyc($urandom % 500 == 0, $urandom % 5 == 0, a, d, $urandom % 3 == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
